// File: rtl/shift_serializer_pkg.sv
// Shared definitions for the bit-serial transmit/receive pair.
// Word width default and counter sizing live here so both ends agree.
package shift_serializer_pkg;

    localparam int unsigned SHIFT_WIDTH = 17;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_serializer.sv
// Parallel-to-serial transmitter: one WIDTH-bit word in, MSB-first bit stream out,
// with zero-bubble back-to-back loading and a synchronous flush.
module shift_serializer
    import shift_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = SHIFT_WIDTH,
    parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
    input  logic             Core_clk,
    input  logic             Core_resetn,
    input  logic             io_dataIn_valid,
    output logic             io_dataIn_ready,
    input  logic [WIDTH-1:0] io_dataIn_payload,
    output logic             io_dataOut_valid,
    input  logic             io_dataOut_ready,
    output logic             io_dataOut_payload,
    input  logic             io_resetBuffer,
    output logic             io_busy,
    output logic [CNT_W-1:0] io_bitsLeft,
    output logic             io_wordDone
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    logic in_fire;
    logic out_fire;
    logic last_bit;

    always_ff @(posedge Core_clk or negedge Core_resetn) begin
        if (!Core_resetn) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        io_dataIn_ready    = 1'b0;
        io_dataOut_valid   = 1'b0;
        io_dataOut_payload = shift_q[WIDTH-1];
        io_busy            = (state_q == SHIFT);
        io_bitsLeft        = count_q;
        io_wordDone        = done_q;
        last_bit           = (state_q == SHIFT) && (count_q == CNT_W'(1));
        if (!io_resetBuffer) begin
            // Ready may follow the sink's ready combinationally on the final bit.
            io_dataIn_ready  = (state_q == IDLE) || (last_bit && io_dataOut_ready);
            io_dataOut_valid = (state_q == SHIFT);
        end
        in_fire  = io_dataIn_valid && io_dataIn_ready;
        out_fire = io_dataOut_valid && io_dataOut_ready;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (io_resetBuffer) begin
            state_d = IDLE;
            shift_d = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        state_d = SHIFT;
                        shift_d = io_dataIn_payload;
                        count_d = CNT_W'(WIDTH);
                    end
                end
                SHIFT: begin
                    if (out_fire) begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        count_d = count_q - CNT_W'(1);
                        if (last_bit) begin
                            done_d = 1'b1;
                            if (in_fire) begin
                                shift_d = io_dataIn_payload;
                                count_d = CNT_W'(WIDTH);
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_serializer.sv
// Randomized bench for shift_serializer: a word-level model predicts every output
// each cycle, and received bits are reassembled and compared against the sent word.
module tb_shift_serializer;
    import shift_serializer_pkg::*;

    localparam int unsigned W  = 17;
    localparam int unsigned CW = cnt_width(W);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_payload;
    logic          out_valid;
    logic          out_ready;
    logic          out_payload;
    logic          reset_buffer;
    logic          busy;
    logic [CW-1:0] bits_left;
    logic          word_done;

    shift_serializer #(.WIDTH(W)) dut (
        .Core_clk          (clk),
        .Core_resetn       (rst_n),
        .io_dataIn_valid   (in_valid),
        .io_dataIn_ready   (in_ready),
        .io_dataIn_payload (in_payload),
        .io_dataOut_valid  (out_valid),
        .io_dataOut_ready  (out_ready),
        .io_dataOut_payload(out_payload),
        .io_resetBuffer    (reset_buffer),
        .io_busy           (busy),
        .io_bitsLeft       (bits_left),
        .io_wordDone       (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Word-level reference: the word in flight and how many of its bits remain.
    logic [W-1:0] tx_q[$];
    logic [W-1:0] cur_word;
    int           rem;
    bit           done_m;
    logic [W-1:0] rx_word;
    int           rx_cnt;
    int           words_rx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        rem    = 0;
        done_m = 0;
        rx_cnt = 0;
    endtask

    // Called just after a rising edge; drives, checks before the next edge, then advances.
    task automatic step(input bit ordy, input bit rb, input bit offer);
        bit exp_ready, exp_valid, exp_in_fire, exp_out_fire;
        logic [W-1:0] next_word;
        in_valid     = offer && (tx_q.size() > 0);
        next_word    = (tx_q.size() > 0) ? tx_q[0] : W'($urandom);
        in_payload   = next_word;
        out_ready    = ordy;
        reset_buffer = rb;
        #4;
        exp_valid    = !rb && (rem > 0);
        exp_ready    = !rb && ((rem == 0) || (rem == 1 && ordy));
        exp_in_fire  = in_valid && exp_ready;
        exp_out_fire = exp_valid && ordy;
        check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
        check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
        check_eq("busy", 32'(busy), 32'(rem > 0));
        check_eq("bits_left", 32'(bits_left), 32'(rem));
        check_eq("word_done", 32'(word_done), 32'(done_m));
        if (exp_valid)
            check_eq("payload", 32'(out_payload), 32'(cur_word[rem-1]));
        if (exp_out_fire) begin
            rx_word = {rx_word[W-2:0], out_payload};
            rx_cnt++;
            if (rx_cnt == int'(W)) begin
                check_eq("loopback_word", 32'(rx_word), 32'(cur_word));
                words_rx++;
                rx_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
        if (rb) begin
            model_reset();
        end else begin
            done_m = 0;
            if (exp_out_fire) begin
                rem--;
                if (rem == 0) done_m = 1;
            end
            if (exp_in_fire) begin
                cur_word = tx_q.pop_front();
                rem      = W;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((tx_q.size() > 0 || rem > 0 || done_m) && n < budget) begin
            step(1'b1, 1'b0, 1'b1);
            n++;
        end
        check_eq("drain_timeout", 32'(n >= budget), 32'(0));
    endtask

    initial begin
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int base;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_payload   = '0;
        out_ready    = 1'b0;
        reset_buffer = 1'b0;
        cur_word     = '0;
        rx_word      = '0;
        words_rx     = 0;
        model_reset();

        // Reset values held, then unchanged after release
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_in_ready", 32'(in_ready), 32'(1));
        check_eq("rst_out_valid", 32'(out_valid), 32'(0));
        check_eq("rst_payload", 32'(out_payload), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_bits_left", 32'(bits_left), 32'(0));
        check_eq("rst_word_done", 32'(word_done), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) step(1'b1, 1'b0, 1'b0);

        // Single word, sink always ready
        tx_q.push_back(17'h1A5C3);
        repeat (20) step(1'b1, 1'b0, 1'b1);
        check_eq("single_words", 32'(words_rx), 32'(1));

        // Back-to-back with valid held
        tx_q.push_back(17'h1FFFF);
        tx_q.push_back(17'h00000);
        repeat (37) step(1'b1, 1'b0, 1'b1);
        check_eq("b2b_words", 32'(words_rx), 32'(3));

        // Backpressure 1,0,0,1
        tx_q.push_back(17'h15555);
        for (int i = 0; i < 80; i++) step(pat[i % 4], 1'b0, 1'b1);
        check_eq("bp_words", 32'(words_rx), 32'(4));

        // Abort after 5 bits, with a new word offered during the abort
        tx_q.push_back(17'h0F0F0);
        step(1'b1, 1'b0, 1'b1);
        tx_q.push_back(17'h00001);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        drain(100);
        check_eq("abort_words", 32'(words_rx), 32'(5));

        // Asynchronous reset mid-word
        tx_q.push_back(W'($urandom));
        repeat (6) step(1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        check_eq("async_busy", 32'(busy), 32'(0));
        check_eq("async_valid", 32'(out_valid), 32'(0));
        check_eq("async_bits_left", 32'(bits_left), 32'(0));
        model_reset();
        rst_n = 1'b1;
        repeat (2) step(1'b1, 1'b0, 1'b0);

        // Random loop-back of 200 words with random valid and backpressure
        base = words_rx;
        for (int i = 0; i < 200; i++) tx_q.push_back(W'($urandom));
        for (int c = 0; c < 20000 && (tx_q.size() > 0 || rem > 0); c++)
            step($urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 4) != 0);
        drain(100);
        check_eq("random_words", 32'(words_rx - base), 32'(200));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
